// File: rtl/tick_counter_bank_pkg.sv
// Shared definitions for the tick counter bank: per-channel mode encoding
// and the width of one channel's mode field.
package tick_counter_bank_pkg;

  localparam int unsigned MODE_BITS = 2;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_SET  = 2'b11
  } tick_mode_e;

endpackage

// File: rtl/tick_counter_bank_channel.sv
// One channel of the tick counter bank: a WIDTH-bit counter bounded to
// 0..in_limit that wraps or saturates at its bounds, plus a registered
// one-cycle terminal flag raised whenever a ticked INC/DEC hits a bound.
module tick_counter_channel
  import tick_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic [MODE_BITS-1:0] in_mode,
  input  logic                 in_tick,
  input  logic [WIDTH-1:0]     in_load_value,
  input  logic [WIDTH-1:0]     in_limit,
  output logic [WIDTH-1:0]     out_value,
  output logic                 out_terminal
);

  logic [WIDTH-1:0] r_value;
  logic             r_terminal;
  logic [WIDTH-1:0] w_nextValue;
  logic             w_nextTerminal;
  tick_mode_e       w_mode;

  assign w_mode = tick_mode_e'(in_mode);

  // Next value and terminal flag; anything above the limit counts as "at limit" for INC.
  always_comb begin
    w_nextValue    = r_value;
    w_nextTerminal = 1'b0;
    case (w_mode)
      MODE_INC: begin
        if (in_tick) begin
          if (r_value >= in_limit) begin
            w_nextTerminal = 1'b1;
            w_nextValue    = (SATURATE != 0) ? in_limit : '0;
          end else begin
            w_nextValue = r_value + WIDTH'(1);
          end
        end
      end
      MODE_DEC: begin
        if (in_tick) begin
          if (r_value == '0) begin
            w_nextTerminal = 1'b1;
            w_nextValue    = (SATURATE != 0) ? '0 : in_limit;
          end else begin
            w_nextValue = r_value - WIDTH'(1);
          end
        end
      end
      MODE_SET: begin
        w_nextValue = in_load_value;
      end
      default: begin
        w_nextValue = r_value;
      end
    endcase
  end

  // Counter and terminal registers, cleared immediately by reset with no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value    <= '0;
      r_terminal <= 1'b0;
    end else begin
      r_value    <= w_nextValue;
      r_terminal <= w_nextTerminal;
    end
  end

  assign out_value    = r_value;
  assign out_terminal = r_terminal;

endmodule

// File: rtl/tick_counter_bank.sv
// Bank of CHANNELS independent tick counters sharing tick, load value and
// limit. Each channel is steered by its own 2-bit mode slice; values and
// terminal pulses are registered, zero flags are decoded combinationally.
module tick_counter_bank
  import tick_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                          rst,
  input  logic                          clk,
  input  logic [MODE_BITS*CHANNELS-1:0] in_mode,
  input  logic                          in_tick,
  input  logic [WIDTH-1:0]              in_load_value,
  input  logic [WIDTH-1:0]              in_limit,
  output logic [WIDTH*CHANNELS-1:0]     out_values,
  output logic [CHANNELS-1:0]           out_terminal,
  output logic [CHANNELS-1:0]           out_zero
);

  logic [WIDTH-1:0] w_values [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
    tick_counter_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_channel (
      .rst           (rst),
      .clk           (clk),
      .in_mode       (in_mode[MODE_BITS*k +: MODE_BITS]),
      .in_tick       (in_tick),
      .in_load_value (in_load_value),
      .in_limit      (in_limit),
      .out_value     (w_values[k]),
      .out_terminal  (out_terminal[k])
    );

    assign out_values[WIDTH*k +: WIDTH] = w_values[k];
    assign out_zero[k]                  = (w_values[k] == '0);
  end

endmodule

// File: tb/tb_tick_counter_bank.sv
// Scoreboard bench for tick_counter_bank: a wrap instance and a saturate
// instance share every input; directed vectors push hand-computed results
// that a negedge monitor pops and compares.
module tb_tick_counter_bank;
  import tick_counter_bank_pkg::*;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk;
  logic           rst;
  logic [2*C-1:0] mode;
  logic           tick;
  logic [W-1:0]   loadValue;
  logic [W-1:0]   limit;
  logic [W*C-1:0] wrapValues, satValues;
  logic [C-1:0]   wrapTerm, satTerm, wrapZero, satZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          name;
    logic [W*C-1:0] wVal;
    logic [C-1:0]   wTerm;
    logic [W*C-1:0] sVal;
    logic [C-1:0]   sTerm;
  } expect_t;

  expect_t scoreboard[$];

  tick_counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(0)) dutWrap (
    .rst(rst), .clk(clk), .in_mode(mode), .in_tick(tick),
    .in_load_value(loadValue), .in_limit(limit),
    .out_values(wrapValues), .out_terminal(wrapTerm), .out_zero(wrapZero)
  );

  tick_counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(1)) dutSat (
    .rst(rst), .clk(clk), .in_mode(mode), .in_tick(tick),
    .in_load_value(loadValue), .in_limit(limit),
    .out_values(satValues), .out_terminal(satTerm), .out_zero(satZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*C-1:0] modes(input tick_mode_e m0, input tick_mode_e m1,
                                           input tick_mode_e m2, input tick_mode_e m3);
    return {m3, m2, m1, m0};
  endfunction

  function automatic logic [W*C-1:0] vals(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                          input logic [W-1:0] v2, input logic [W-1:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  function automatic logic [C-1:0] zerosOf(input logic [W*C-1:0] v);
    logic [C-1:0] z;
    for (int k = 0; k < C; k++) z[k] = (v[W*k +: W] == '0);
    return z;
  endfunction

  task automatic checkOutput(input string name, input logic [W*C-1:0] actual,
                             input logic [W*C-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one vector, then queue its response once the edge has consumed it.
  task automatic applyStimulus(input string name, input logic [2*C-1:0] m, input logic t,
                               input logic [W-1:0] ld, input logic [W-1:0] lim,
                               input logic [W*C-1:0] wv, input logic [C-1:0] wt,
                               input logic [W*C-1:0] sv, input logic [C-1:0] st);
    expect_t e;
    mode = m; tick = t; loadValue = ld; limit = lim;
    @(posedge clk);
    #1;
    e.name = name; e.wVal = wv; e.wTerm = wt; e.sVal = sv; e.sTerm = st;
    scoreboard.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every queued expectation against both instances.
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      expect_t e;
      e = scoreboard.pop_front();
      checkOutput({e.name, " wrapValues"}, wrapValues, e.wVal);
      checkOutput({e.name, " wrapTerm"}, W*C'(wrapTerm), W*C'(e.wTerm));
      checkOutput({e.name, " wrapZero"}, W*C'(wrapZero), W*C'(zerosOf(e.wVal)));
      checkOutput({e.name, " satValues"}, satValues, e.sVal);
      checkOutput({e.name, " satTerm"}, W*C'(satTerm), W*C'(e.sTerm));
      checkOutput({e.name, " satZero"}, W*C'(satZero), W*C'(zerosOf(e.sVal)));
    end
  end

  task automatic checkCleared(input string name);
    checkOutput({name, " wrapValues"}, wrapValues, '0);
    checkOutput({name, " wrapTerm"}, W*C'(wrapTerm), '0);
    checkOutput({name, " wrapZero"}, W*C'(wrapZero), W*C'(4'b1111));
    checkOutput({name, " satValues"}, satValues, '0);
    checkOutput({name, " satTerm"}, W*C'(satTerm), '0);
    checkOutput({name, " satZero"}, W*C'(satZero), W*C'(4'b1111));
  endtask

  initial begin
    rst = 1'b1;
    mode = '0; tick = 1'b0; loadValue = '0; limit = '0;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    rst = 1'b0;

    // Wrap/saturate INC on ch0, limit 3
    applyStimulus("incA1", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 3,
                  vals(1,0,0,0), 4'b0000, vals(1,0,0,0), 4'b0000);
    applyStimulus("incA2", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 3,
                  vals(2,0,0,0), 4'b0000, vals(2,0,0,0), 4'b0000);
    applyStimulus("incA3", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 3,
                  vals(3,0,0,0), 4'b0000, vals(3,0,0,0), 4'b0000);
    applyStimulus("incA4", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 3,
                  vals(0,0,0,0), 4'b0001, vals(3,0,0,0), 4'b0001);
    applyStimulus("incA5", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 3,
                  vals(1,0,0,0), 4'b0000, vals(3,0,0,0), 4'b0001);

    // SET ch1 to 2 then DEC through zero
    applyStimulus("decB0", modes(MODE_HOLD, MODE_SET, MODE_HOLD, MODE_HOLD), 1, 2, 3,
                  vals(1,2,0,0), 4'b0000, vals(3,2,0,0), 4'b0000);
    applyStimulus("decB1", modes(MODE_HOLD, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 2, 3,
                  vals(1,1,0,0), 4'b0000, vals(3,1,0,0), 4'b0000);
    applyStimulus("decB2", modes(MODE_HOLD, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 2, 3,
                  vals(1,0,0,0), 4'b0000, vals(3,0,0,0), 4'b0000);
    applyStimulus("decB3", modes(MODE_HOLD, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 2, 3,
                  vals(1,3,0,0), 4'b0010, vals(3,0,0,0), 4'b0010);
    applyStimulus("decB4", modes(MODE_HOLD, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 2, 3,
                  vals(1,2,0,0), 4'b0000, vals(3,0,0,0), 4'b0010);

    // Tick gating on ch2, then SET without tick
    applyStimulus("gateC1", modes(MODE_HOLD, MODE_HOLD, MODE_INC, MODE_HOLD), 1, 0, 255,
                  vals(1,2,1,0), 4'b0000, vals(3,0,1,0), 4'b0000);
    applyStimulus("gateC2", modes(MODE_HOLD, MODE_HOLD, MODE_INC, MODE_HOLD), 0, 0, 255,
                  vals(1,2,1,0), 4'b0000, vals(3,0,1,0), 4'b0000);
    applyStimulus("gateC3", modes(MODE_HOLD, MODE_HOLD, MODE_INC, MODE_HOLD), 1, 0, 255,
                  vals(1,2,2,0), 4'b0000, vals(3,0,2,0), 4'b0000);
    applyStimulus("gateC4", modes(MODE_HOLD, MODE_HOLD, MODE_INC, MODE_HOLD), 0, 0, 255,
                  vals(1,2,2,0), 4'b0000, vals(3,0,2,0), 4'b0000);
    applyStimulus("gateC5", modes(MODE_HOLD, MODE_HOLD, MODE_SET, MODE_HOLD), 0, 8'hA5, 255,
                  vals(1,2,8'hA5,0), 4'b0000, vals(3,0,8'hA5,0), 4'b0000);

    // Out-of-range value on ch3 with limit 5
    applyStimulus("oorD1", modes(MODE_HOLD, MODE_HOLD, MODE_HOLD, MODE_SET), 0, 10, 5,
                  vals(1,2,8'hA5,10), 4'b0000, vals(3,0,8'hA5,10), 4'b0000);
    applyStimulus("oorD2", modes(MODE_HOLD, MODE_HOLD, MODE_HOLD, MODE_INC), 1, 10, 5,
                  vals(1,2,8'hA5,0), 4'b1000, vals(3,0,8'hA5,5), 4'b1000);
    applyStimulus("oorD3", modes(MODE_HOLD, MODE_HOLD, MODE_HOLD, MODE_SET), 1, 10, 5,
                  vals(1,2,8'hA5,10), 4'b0000, vals(3,0,8'hA5,10), 4'b0000);
    applyStimulus("oorD4", modes(MODE_HOLD, MODE_HOLD, MODE_HOLD, MODE_DEC), 1, 10, 5,
                  vals(1,2,8'hA5,9), 4'b0000, vals(3,0,8'hA5,9), 4'b0000);

    // Limit 0: INC on ch0, DEC on ch1
    applyStimulus("lim0E1", modes(MODE_INC, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 0, 0,
                  vals(0,1,8'hA5,9), 4'b0001, vals(0,0,8'hA5,9), 4'b0011);
    applyStimulus("lim0E2", modes(MODE_INC, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 0, 0,
                  vals(0,0,8'hA5,9), 4'b0001, vals(0,0,8'hA5,9), 4'b0011);
    applyStimulus("lim0E3", modes(MODE_INC, MODE_DEC, MODE_HOLD, MODE_HOLD), 1, 0, 0,
                  vals(0,0,8'hA5,9), 4'b0011, vals(0,0,8'hA5,9), 4'b0011);

    // Count ch0 to 2, then reset asynchronously between edges
    applyStimulus("runF1", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 255,
                  vals(1,0,8'hA5,9), 4'b0000, vals(1,0,8'hA5,9), 4'b0000);
    applyStimulus("runF2", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 255,
                  vals(2,0,8'hA5,9), 4'b0000, vals(2,0,8'hA5,9), 4'b0000);
    #2 rst = 1'b1;
    #1 checkCleared("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("resumeF3", modes(MODE_INC, MODE_HOLD, MODE_HOLD, MODE_HOLD), 1, 0, 255,
                  vals(1,0,0,0), 4'b0000, vals(1,0,0,0), 4'b0000);

    @(negedge clk);
    checkOutput("scoreboardDrained", W*C'(scoreboard.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
